// File: rtl/mips_cpu_pkg.sv
// Shared CPU package: default register-file geometry and the architectural register address type.
package mips_cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] regfile_addr_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Write-port priority resolver: reports whether any write port targets query_addr this
// cycle and, if several do, returns the data of the highest-indexed one.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_WR   = 2
) (
    input  logic [N_WR-1:0]              wr_en,
    input  logic [N_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [N_WR-1:0][DATA_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0]            query_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan: a later (higher-index) match overrides an earlier one.
        for (int p = 0; p < N_WR; p++) begin
            if (wr_en[p] && (wr_addr[p] == query_addr) && (query_addr != '0)) begin
                hit  = 1'b1;
                data = wr_data[p];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with HI/LO registers and a per-register pending-write
// scoreboard that blocks a second issue to a destination still awaiting its write.
module regfile_scoreboard
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2,
    parameter int BYPASS = 1
) (
    input  logic                         modified_write_clk,
    input  logic                         reset,
    input  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [N_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [N_RD-1:0]              rd_busy,
    input  logic [N_WR-1:0]              wr_en,
    input  logic [N_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [N_WR-1:0][DATA_W-1:0]  wr_data,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ready,
    input  logic                         hi_we,
    input  logic                         lo_we,
    input  logic [DATA_W-1:0]            hi_wdata,
    input  logic [DATA_W-1:0]            lo_wdata,
    output logic [DATA_W-1:0]            hi_rdata,
    output logic [DATA_W-1:0]            lo_rdata,
    output logic [ADDR_W:0]              pending_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit FWD   = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DEPTH-1:0]  pending, pending_n, clear_mask, set_mask;
    logic [ADDR_W:0]   count_n;
    logic              issue_clr_hit;
    logic [DATA_W-1:0] sb_unused_data;

    // NOTE: the whole array is cleared asynchronously because reset must zero every
    // register; this rules out mapping it onto a RAM macro.
    always_ff @(posedge modified_write_clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
        end else begin
            // NOTE: non-blocking updates; with several ports on one address the last
            // assignment in loop order (highest port index) is the one that lands.
            for (int p = 0; p < N_WR; p++) begin
                if (wr_en[p] && (wr_addr[p] != '0)) regs[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    always_ff @(posedge modified_write_clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

    assign hi_rdata = (FWD && hi_we && !reset) ? hi_wdata : hi_q;
    assign lo_rdata = (FWD && lo_we && !reset) ? lo_wdata : lo_q;

    regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR)) u_sb_arb (
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .query_addr (issue_addr),
        .hit        (issue_clr_hit),
        .data       (sb_unused_data)
    );

    // A write landing this cycle frees the destination, so the issue may proceed.
    assign issue_ready = !(pending[issue_addr] && !issue_clr_hit);

    always_comb begin
        clear_mask = '0;
        set_mask   = '0;
        for (int p = 0; p < N_WR; p++) begin
            if (wr_en[p] && (wr_addr[p] != '0)) clear_mask[wr_addr[p]] = 1'b1;
        end
        if (issue_valid && issue_ready) set_mask[issue_addr] = 1'b1;
        // Set after clear: an issue paired with a same-cycle write is the younger op.
        pending_n    = (pending & ~clear_mask) | set_mask;
        pending_n[0] = 1'b0;
        // Bit 0 is never set, so the count tops out at DEPTH-1 and cannot wrap.
        count_n = '0;
        for (int a = 0; a < DEPTH; a++) count_n = count_n + (ADDR_W+1)'(pending_n[a]);
    end

    always_ff @(posedge modified_write_clk or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            pending       <= pending_n;
            pending_count <= count_n;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic              hit;
        logic [DATA_W-1:0] fwd_data;

        regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR)) u_rd_arb (
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .query_addr (rd_addr[i]),
            .hit        (hit),
            .data       (fwd_data)
        );

        assign rd_data[i] = (rd_addr[i] == '0)      ? '0       :
                            (FWD && hit && !reset)  ? fwd_data : regs[rd_addr[i]];
        assign rd_busy[i] = pending[rd_addr[i]] && !(FWD && hit);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file and scoreboard.
module tb_regfile_scoreboard;
    import mips_cpu_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             issue_valid;
    logic [4:0]       issue_addr;
    logic             issue_ready;
    logic             hi_we, lo_we;
    logic [31:0]      hi_wdata, lo_wdata, hi_rdata, lo_rdata;
    logic [5:0]       pending_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [31:0] m_hi, m_lo;
    int          m_count;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .modified_write_clk (clk),
        .reset              (reset),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .rd_busy            (rd_busy),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .issue_valid        (issue_valid),
        .issue_addr         (issue_addr),
        .issue_ready        (issue_ready),
        .hi_we              (hi_we),
        .lo_we              (lo_we),
        .hi_wdata           (hi_wdata),
        .lo_wdata           (lo_wdata),
        .hi_rdata           (hi_rdata),
        .lo_rdata           (lo_rdata),
        .pending_count      (pending_count)
    );

    function automatic bit wr_hit(input regfile_addr_t a, output logic [31:0] d);
        bit h = 0;
        d = '0;
        if (a == 0) return 0;
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p] == a) begin h = 1; d = wr_data[p]; end
        return h;
    endfunction

    function automatic logic [31:0] exp_rd_data(input regfile_addr_t a);
        logic [31:0] d;
        if (a == 0) return '0;
        if (wr_hit(a, d)) return d;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input regfile_addr_t a);
        logic [31:0] d;
        return (a != 0) && m_pend[a] && !wr_hit(a, d);
    endfunction

    function automatic bit exp_ready();
        logic [31:0] d;
        return !(m_pend[issue_addr] && !wr_hit(issue_addr, d));
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin m_regs[a] = '0; m_pend[a] = 0; end
        m_hi = '0; m_lo = '0; m_count = 0;
    endtask

    task automatic model_apply();
        bit acc = issue_valid && exp_ready() && (issue_addr != 0);
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p] != 0) begin
                m_regs[wr_addr[p]] = wr_data[p];
                m_pend[wr_addr[p]] = 0;
            end
        if (acc) m_pend[issue_addr] = 1;
        if (hi_we) m_hi = hi_wdata;
        if (lo_we) m_lo = lo_wdata;
        m_count = 0;
        for (int a = 0; a < 32; a++) m_count += int'(m_pend[a]);
    endtask

    // Advance one clock edge, updating the model with the inputs the DUT sees at it.
    task automatic tick();
        if (reset) model_reset(); else model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_valid = 0; issue_addr = '0;
        hi_we = 0; lo_we = 0; hi_wdata = '0; lo_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        model_reset();
        #2;
        checks++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL reset_reads rd_data=%h rd_busy=%b required 0/00", rd_data, rd_busy);
        end
        checks++;
        if (issue_ready !== 1'b1 || pending_count !== 6'd0) begin
            failures++;
            $display("FAIL reset_sb issue_ready=%b pending_count=%0d required 1/0", issue_ready, pending_count);
        end
        checks++;
        if (hi_rdata !== '0 || lo_rdata !== '0) begin
            failures++;
            $display("FAIL reset_hilo hi=%h lo=%h required 0/0", hi_rdata, lo_rdata);
        end
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_same_addr_priority();
        idle();
        wr_en = 2'b11; wr_addr[0] = 5; wr_data[0] = 32'h11; wr_addr[1] = 5; wr_data[1] = 32'h22;
        rd_addr[0] = 5;
        #1;
        checks++;
        if (rd_data[0] !== 32'h22) begin
            failures++;
            $display("FAIL prio_bypass rd_data=%h required 00000022", rd_data[0]);
        end
        tick();
        idle();
        rd_addr[1] = 5;
        #1;
        checks++;
        if (rd_data[1] !== 32'h22) begin
            failures++;
            $display("FAIL prio_stored rd_data=%h required 00000022", rd_data[1]);
        end
    endtask

    task automatic test_zero_write();
        idle();
        wr_en[0] = 1; wr_addr[0] = 0; wr_data[0] = 32'hFFFF_FFFF;
        rd_addr[0] = 0;
        #1;
        checks++;
        if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_write_rd rd_data=%h busy=%b required 0/0", rd_data[0], rd_busy[0]);
        end
        tick();
        checks++;
        if (rd_data[0] !== '0 || pending_count !== 6'd0) begin
            failures++;
            $display("FAIL zero_write_after rd_data=%h count=%0d required 0/0", rd_data[0], pending_count);
        end
    endtask

    task automatic test_issue_then_write();
        idle();
        issue_valid = 1; issue_addr = 7;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue7_ready got=%b required 1", issue_ready);
        end
        tick();
        issue_valid = 0; rd_addr[0] = 7;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || pending_count !== 6'd1 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL issue7_pending busy=%b count=%0d ready=%b required 1/1/0",
                     rd_busy[0], pending_count, issue_ready);
        end
        wr_en[1] = 1; wr_addr[1] = 7; wr_data[1] = 32'h5;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL write7_bypass busy=%b ready=%b required 0/1", rd_busy[0], issue_ready);
        end
        tick();
        wr_en = '0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || pending_count !== 6'd0 || rd_data[0] !== 32'h5) begin
            failures++;
            $display("FAIL write7_after busy=%b count=%0d data=%h required 0/0/00000005",
                     rd_busy[0], pending_count, rd_data[0]);
        end
    endtask

    task automatic test_issue_write_same();
        idle();
        issue_valid = 1; issue_addr = 9;
        wr_en[0] = 1; wr_addr[0] = 9; wr_data[0] = 32'hA;
        tick();
        idle();
        rd_addr[0] = 9;
        #1;
        checks++;
        if (rd_data[0] !== 32'hA || rd_busy[0] !== 1'b1 || pending_count !== 6'd1) begin
            failures++;
            $display("FAIL issue_write9 data=%h busy=%b count=%0d required 0000000a/1/1",
                     rd_data[0], rd_busy[0], pending_count);
        end
    endtask

    task automatic test_hilo();
        idle();
        lo_we = 1; lo_wdata = 32'h1234;
        tick();
        idle();
        hi_we = 1; hi_wdata = 32'hDEAD;
        #1;
        checks++;
        if (hi_rdata !== 32'hDEAD || lo_rdata !== 32'h1234) begin
            failures++;
            $display("FAIL hilo_bypass hi=%h lo=%h required 0000dead/00001234", hi_rdata, lo_rdata);
        end
        tick();
        idle();
        #1;
        checks++;
        if (hi_rdata !== 32'hDEAD || lo_rdata !== 32'h1234) begin
            failures++;
            $display("FAIL hilo_stored hi=%h lo=%h required 0000dead/00001234", hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_async_reset();
        int addrs[3] = '{5, 7, 12};
        for (int k = 0; k < 3; k++) begin
            idle();
            issue_valid = 1; issue_addr = 5'(addrs[k]);
            tick();
        end
        idle();
        rd_addr[0] = 5; rd_addr[1] = 9; issue_addr = 9;
        #1;
        checks++;
        if (pending_count !== 6'd4 || rd_data[0] !== 32'h22 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset count=%0d data=%h ready=%b required 4/00000022/0",
                     pending_count, rd_data[0], issue_ready);
        end
        reset = 1;
        #1;
        checks++;
        if (pending_count !== 6'd0 || rd_data !== '0 || rd_busy !== 2'b00 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset count=%0d data=%h busy=%b ready=%b required 0/0/00/1",
                     pending_count, rd_data, rd_busy, issue_ready);
        end
        checks++;
        if (hi_rdata !== '0 || lo_rdata !== '0) begin
            failures++;
            $display("FAIL async_reset_hilo hi=%h lo=%h required 0/0", hi_rdata, lo_rdata);
        end
        model_reset();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            // Small address range so ports collide and issues hit pending registers often.
            for (int p = 0; p < 2; p++) begin
                rd_addr[p] = 5'($urandom_range(0, 7));
                wr_en[p]   = ($urandom_range(0, 2) == 0);
                wr_addr[p] = 5'($urandom_range(0, 7));
                wr_data[p] = $urandom;
            end
            issue_valid = $urandom_range(0, 1) == 1;
            issue_addr  = 5'($urandom_range(0, 7));
            hi_we = $urandom_range(0, 3) == 0; hi_wdata = $urandom;
            lo_we = $urandom_range(0, 3) == 0; lo_wdata = $urandom;
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rd_data[p] !== exp_rd_data(rd_addr[p]) || rd_busy[p] !== exp_busy(rd_addr[p])) begin
                    failures++;
                    $display("FAIL rand_rd c=%0d port=%0d addr=%0d data=%h busy=%b required %h/%b",
                             c, p, rd_addr[p], rd_data[p], rd_busy[p],
                             exp_rd_data(rd_addr[p]), exp_busy(rd_addr[p]));
                end
            end
            checks++;
            if (issue_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rand_ready c=%0d addr=%0d got=%b required %b",
                         c, issue_addr, issue_ready, exp_ready());
            end
            checks++;
            if (hi_rdata !== (hi_we ? hi_wdata : m_hi) || lo_rdata !== (lo_we ? lo_wdata : m_lo)) begin
                failures++;
                $display("FAIL rand_hilo c=%0d hi=%h lo=%h", c, hi_rdata, lo_rdata);
            end
            tick();
            checks++;
            if (pending_count !== 6'(m_count)) begin
                failures++;
                $display("FAIL rand_count c=%0d got=%0d required %0d", c, pending_count, m_count);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_same_addr_priority();
        test_zero_write();
        test_issue_then_write();
        test_issue_write_same();
        test_hilo();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- N_RD, 2, number of read ports.
- N_WR, 2, number of write ports.
- BYPASS, 1, 1 = write-to-read forwarding enabled.
REQ-002 Reset SHALL be `reset`, asynchronous, active-high; the clock SHALL be `modified_write_clk`.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- modified_write_clk, in, 1, all state updates on posedge.
- reset, in, 1, asynchronous active-high clear.
- rd_addr, in, N_RD x ADDR_W, read addresses.
- rd_data, out, N_RD x DATA_W, read data.
- rd_busy, out, N_RD, addressed register has a pending write.
- wr_en, in, N_WR, write strobes.
- wr_addr, in, N_WR x ADDR_W, write addresses.
- wr_data, in, N_WR x DATA_W, write data.
- issue_valid, in, 1, request to mark a destination pending.
- issue_addr, in, ADDR_W, destination to mark.
- issue_ready, out, 1, issue acceptable this cycle.
- hi_we / lo_we, in, 1 each, HI/LO write strobes.
- hi_wdata / lo_wdata, in, DATA_W each, HI/LO write data.
- hi_rdata / lo_rdata, out, DATA_W each, HI/LO contents.
- pending_count, out, ADDR_W+1, number of pending registers.

Function
REQ-004 Reads SHALL be combinational; an rd_addr of 0 SHALL return 0 and rd_busy=0.
REQ-005 A write to address 0 SHALL be discarded and SHALL have no effect on the scoreboard.
REQ-006 Accepted writes SHALL update the array on posedge modified_write_clk; if multiple ports write the same address in one cycle, the highest port index SHALL win.
REQ-007 When BYPASS=1, a read of an address written in the same cycle SHALL return the winning wr_data combinationally; when BYPASS=0, it SHALL return the stored value.
REQ-008 HI/LO SHALL write independently on hi_we/lo_we; when BYPASS=1, hi_rdata/lo_rdata SHALL forward same-cycle write data.
REQ-009 The scoreboard SHALL hold one pending bit per register; bit 0 SHALL be held at 0.
REQ-010 issue_ready SHALL be 0 when pending[issue_addr]=1 and no write clears that bit this cycle (WAW block); otherwise issue_ready SHALL be 1.
REQ-011 An issue SHALL be accepted on issue_valid && issue_ready; acceptance SHALL set pending[issue_addr] at the next edge, except that issue_addr=0 SHALL be accepted and ignored.
REQ-012 A write to address a SHALL clear pending[a] at the edge.
REQ-013 If an issue and a write target the same address in the same cycle, the register SHALL take the write data and pending SHALL end set (the issue is younger).
REQ-014 rd_busy[i] SHALL equal pending[rd_addr[i]]; when BYPASS=1, rd_busy[i] SHALL be 0 if the same cycle's write clears that bit.
REQ-015 pending_count SHALL be registered, SHALL equal the population of pending bits after each edge, and SHALL never wrap (maximum 2**ADDR_W-1).

Reset
REQ-016 While reset is high, all registers, HI, LO and pending bits, and pending_count SHALL be 0.
REQ-017 As a consequence of REQ-016, during reset rd_data=0, rd_busy=0 and issue_ready=1.
REQ-018 Assertion of reset mid-operation SHALL discard all pending state immediately, without waiting for a clock edge.

Structure
REQ-019 The DATA_W and ADDR_W defaults and a regfile_addr_t typedef SHALL live in the shared package mips_cpu_pkg.
REQ-020 The write-port priority resolver (address match plus highest-index select) SHALL be a sub-module named regfile_wr_arbiter, instantiated once per read port and once for the scoreboard.

Verification
REQ-021 Scenario: wr port0 addr5=0x11 and port1 addr5=0x22 in the same cycle -> reg5=0x22; same-cycle rd_addr=5 returns 0x22 (BYPASS=1).
REQ-022 Scenario: write addr0=0xFFFFFFFF -> rd_addr=0 returns 0; pending_count unchanged.
REQ-023 Scenario: issue addr7 -> next cycle rd_busy=1, pending_count=1, issue_ready=0 for addr7; write addr7=0x5 -> rd_busy=0 and pending_count=0 after the edge.
REQ-024 Scenario: issue addr9 and write addr9=0xA in the same cycle -> reg9=0xA, pending[9]=1, pending_count=1.
REQ-025 Scenario: hi_we=1 with 0xDEAD and lo_we=0 -> hi_rdata=0xDEAD, lo_rdata unchanged.
REQ-026 Scenario: issue 3 registers, then assert reset between edges -> pending_count=0, all reads 0 and issue_ready=1, all before the next edge.
